// File: rtl/key_pattern_tx.sv
// key_pattern_tx: drives the correct key, each single-bit-inverted key, then all-zeros
// onto a lock detector and checks its unlock response on the last cycle of each pattern.
module key_pattern_tx #(
    parameter int                   KEY_WIDTH     = 5,
    parameter logic [KEY_WIDTH-1:0] KEY_VALUE     = 5'b11111,
    parameter int                   SETTLE_CYCLES = 3,
    parameter int                   STEP_W        = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 unlocked_in,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [STEP_W-1:0]    fail_step
);
    localparam int CNT_W = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [STEP_W-1:0] LAST = STEP_W'(KEY_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t r_state, w_state;
    logic [STEP_W-1:0] r_step, w_step, r_fail_step, w_fail_step;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [KEY_WIDTH-1:0] r_key, w_key;
    logic r_busy, w_busy, r_done, w_done, r_pass, w_pass, r_fail, w_fail;
    logic w_match;

    // Step 0 is the key itself, 1..KEY_WIDTH flip one bit, LAST is all zeros.
    function automatic logic [KEY_WIDTH-1:0] pattern(input logic [STEP_W-1:0] s);
        logic [KEY_WIDTH-1:0] p;
        p = KEY_VALUE;
        for (int i = 0; i < KEY_WIDTH; i++)
            if (s == STEP_W'(i + 1)) p[i] = ~p[i];
        return (s == LAST) ? '0 : p;
    endfunction

    assign w_match = unlocked_in == (r_step == '0);

    always_comb begin
        w_state     = r_state;
        w_step      = r_step;
        w_cnt       = r_cnt;
        w_key       = r_key;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_pass      = r_pass;
        w_fail      = r_fail;
        w_fail_step = r_fail_step;
        if (r_state == S_IDLE) begin
            if (start && !abort) begin
                w_state = S_RUN;
                w_step  = '0;
                w_cnt   = '0;
                w_key   = pattern('0);
                w_busy  = 1'b1;
                w_pass  = 1'b0;
                w_fail  = 1'b0;
            end
        end else if (abort) begin
            w_state = S_IDLE;
            w_key   = '0;
            w_busy  = 1'b0;
        end else if (r_cnt != CNT_MAX) begin
            w_cnt = r_cnt + CNT_W'(1);
        end else if (!w_match) begin
            w_state     = S_IDLE;
            w_fail      = 1'b1;
            w_fail_step = r_step;
            w_done      = 1'b1;
            w_busy      = 1'b0;
            w_key       = '0;
        end else if (r_step == LAST) begin
            w_state = S_IDLE;
            w_pass  = 1'b1;
            w_done  = 1'b1;
            w_busy  = 1'b0;
            w_key   = '0;
        end else begin
            w_step = r_step + STEP_W'(1);
            w_cnt  = '0;
            w_key  = pattern(r_step + STEP_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_cnt       <= '0;
            r_key       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_step <= '0;
        end else begin
            r_state     <= w_state;
            r_step      <= w_step;
            r_cnt       <= w_cnt;
            r_key       <= w_key;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_pass      <= w_pass;
            r_fail      <= w_fail;
            r_fail_step <= w_fail_step;
        end
    end

    assign key_out   = r_key;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign fail_step = r_fail_step;
endmodule

// File: tb/tb_key_pattern_tx.sv
// tb_key_pattern_tx: detector modelled as a 32-entry truth table over key_out; a run-level
// model predicts every output cycle by cycle, plus directed runs with literal expectations.
module tb_key_pattern_tx;
    localparam int S = 3;
    localparam int LASTS = 6;

    logic clk = 1'b0;
    logic rst, start, abort, unlocked_in;
    logic [4:0] key_out;
    logic busy, done, pass, fail;
    logic [2:0] fail_step;
    logic [31:0] tbl;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    assign unlocked_in = tbl[key_out];

    key_pattern_tx dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .unlocked_in(unlocked_in),
        .key_out(key_out), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .fail_step(fail_step)
    );

    function automatic logic [4:0] pat(input int s);
        if (s == 0) return 5'b11111;
        if (s <= 5) return 5'b11111 ^ 5'(1 << (s - 1));
        return 5'b00000;
    endfunction

    // First step whose detector response disagrees with the expectation, -1 for a clean run.
    function automatic int first_fail(input logic [31:0] t);
        for (int s = 0; s <= LASTS; s++)
            if (t[pat(s)] != (s == 0)) return s;
        return -1;
    endfunction

    function automatic int run_len(input int fs);
        return (fs < 0) ? (LASTS + 1) * S : (fs + 1) * S;
    endfunction

    logic m_active, m_done, m_pass, m_fail;
    int m_t, m_fs, m_fstep;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_pass   <= 1'b0;
            m_fail   <= 1'b0;
            m_fstep  <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_active) begin
                if (start && !abort) begin
                    m_active <= 1'b1;
                    m_t      <= 0;
                    m_pass   <= 1'b0;
                    m_fail   <= 1'b0;
                    m_fs     <= first_fail(tbl);
                end
            end else if (abort) begin
                m_active <= 1'b0;
            end else if (m_t + 1 == run_len(m_fs)) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
                if (m_fs < 0) m_pass <= 1'b1;
                else begin
                    m_fail  <= 1'b1;
                    m_fstep <= m_fs;
                end
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("key_out", 32'(key_out), m_active ? 32'(pat(m_t / S)) : 32'd0);
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_done));
            chk("pass", 32'(pass), 32'(m_pass));
            chk("fail", 32'(fail), 32'(m_fail));
            if (m_fail) chk("fail_step", 32'(fail_step), 32'(m_fstep));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_dir(input logic [31:0] t, input int eb, input logic ep, input int es,
                           input bit noisy);
        logic [4:0] seq[$];
        logic [4:0] exp_seq[7];
        int n;
        exp_seq = '{5'b11111, 5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111, 5'b00000};
        tbl = t;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("dir_pass_cleared", 32'(pass), 32'd0);
        n = 0;
        while (busy && n < 100) begin
            seq.push_back(key_out);
            n++;
            if (noisy) start = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        chk("dir_busy_len", 32'(n), 32'(eb));
        chk("dir_done", 32'(done), 32'd1);
        chk("dir_pass", 32'(pass), 32'(ep));
        chk("dir_fail", 32'(fail), 32'(!ep));
        if (!ep) chk("dir_fail_step", 32'(fail_step), 32'(es));
        if (ep && seq.size() == 21)
            for (int i = 0; i < 21; i++) chk("dir_key_seq", 32'(seq[i]), 32'(exp_seq[i / 3]));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_active && n < 100) begin
            tick();
            n++;
        end
        if (m_active) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tbl = 32'h8000_0000;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_key", 32'(key_out), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_flags", 32'({done, pass, fail, fail_step}), 32'd0);

        run_dir(32'h8000_0000, 21, 1'b1, 0, 1'b0);
        run_dir(32'h8000_0000, 21, 1'b1, 0, 1'b0);
        tick();
        run_dir(32'hFFFF_FFFF, 6, 1'b0, 1, 1'b0);
        tick();
        run_dir(32'h0000_0000, 3, 1'b0, 0, 1'b0);
        tick();
        run_dir(32'h8800_0000, 12, 1'b0, 3, 1'b0);
        tick();
        run_dir(32'h8000_0000, 21, 1'b1, 0, 1'b1);
        tick();

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 32'd0);

        tbl = 32'h8000_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_key", 32'(key_out), 32'd0);
        chk("abort_flags", 32'({done, pass, fail}), 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_outs", 32'({key_out, busy, done, pass, fail, fail_step}), 32'd0);

        for (int it = 0; it < 60; it++) begin
            wait_idle();
            case ($urandom_range(0, 3))
                0: tbl = 32'h8000_0000;
                1: tbl = 32'h8000_0000 ^ (32'd1 << $urandom_range(0, 31));
                2: tbl = $urandom;
                default: tbl = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFE);
            endcase
            start = 1'b1;
            for (int c = 0; c < 40; c++) begin
                tick();
                start = ($urandom_range(0, 3) == 0);
                abort = ($urandom_range(0, 39) == 0);
                rst = ($urandom_range(0, 79) == 0);
            end
            start = 1'b0;
            abort = 1'b0;
            rst = 1'b0;
        end
        wait_idle();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_pattern_tx.md
Name: key_pattern_tx

Overview:
- Stimulus generator and checker for the 5-input AND-type unlock detector: drives candidate key patterns onto the detector's input bus and checks its single-bit unlock response.
- After a start pulse it runs a fixed sequence:
  - the correct key (unlock expected),
  - every single-bit-inverted variant of the key (lock expected),
  - all-zeros (lock expected).
- It then reports pass/fail and the first failing step.
- Sits beside the lock detector in a tile, or in the bench, as the opposite end of its key interface.

Parameters:
- KEY_WIDTH, 5, width of the key bus driven to the detector.
- KEY_VALUE, 5'b11111, correct key pattern (KEY_WIDTH bits).
- SETTLE_CYCLES, 3, cycles each pattern is held; unlocked_in is sampled on the last one (legal range >= 1).
- STEP_W, 3, step index width; must hold KEY_WIDTH+1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE only.
- abort  in  1  cancel a run in progress.
- unlocked_in  in  1  detector's unlock output.
- key_out  out  KEY_WIDTH  pattern driven to the detector.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when a run completes (pass or fail).
- pass  out  1  sticky: last run passed.
- fail  out  1  sticky: last run failed.
- fail_step  out  STEP_W  first failing step; valid only while fail=1.

Behaviour:
- Reset values: key_out=0, busy=0, done=0, pass=0, fail=0, fail_step=0, state IDLE, step=0, cnt=0. Reset overrides everything, including mid-run: it returns to IDLE with no done pulse.
- Steps and patterns, LAST = KEY_WIDTH+1:
  - step 0: pattern = KEY_VALUE, expected unlocked_in = 1.
  - step s (1..KEY_WIDTH): pattern = KEY_VALUE with bit s-1 inverted, expected 0.
  - step LAST: pattern = all zeros, expected 0.
- IDLE:
  - On an edge with start=1 and abort=0: go to RUN, step=0, cnt=0, key_out=pattern(0), busy=1, pass=0, fail=0.
  - Otherwise hold; key_out stays 0.
- RUN, each edge:
  - abort=1: go to IDLE, key_out=0, busy=0, no done, pass/fail remain 0.
  - cnt<SETTLE_CYCLES-1: cnt+1.
  - cnt=SETTLE_CYCLES-1, unlocked_in != expected(step): go to IDLE, fail=1, fail_step=step, done=1, busy=0, key_out=0.
  - cnt=SETTLE_CYCLES-1, match and step=LAST: go to IDLE, pass=1, done=1, busy=0, key_out=0.
  - cnt=SETTLE_CYCLES-1, match otherwise: step+1, cnt=0, key_out=pattern(step+1).
- Outputs:
  - All outputs are registered; key_out changes only on step boundaries.
  - done is high exactly one cycle, the cycle after busy falls.
- Timing: a full passing run keeps busy high for (KEY_WIDTH+2)*SETTLE_CYCLES cycles, 21 with defaults. A failure at step s ends after (s+1)*SETTLE_CYCLES cycles.
- start while busy is ignored.
- start and abort on the same edge in IDLE: abort wins, start is ignored.
- start on the edge where done is high is accepted: state is already IDLE; pass/fail clear.
- unlocked_in is consumed directly; no synchroniser (same clock domain as the detector).

Test Plan:
- Connect unlocked_in to AND(key_out[4:0]); pulse start -> busy high 21 cycles, key_out sequence 11111, 11110, 11101, 11011, 10111, 01111, 00000 (3 cycles each), then done pulse, pass=1, fail=0.
- unlocked_in tied 1 -> fail at step 1: busy 6 cycles, done, fail=1, fail_step=1.
- unlocked_in tied 0 -> busy 3 cycles, fail=1, fail_step=0.
- Detector ignores bit 2, i.e. AND of bits 0,1,3,4 -> fail=1, fail_step=3 after 12 busy cycles.
- Mid-run events:
  - abort at cycle 8 -> next cycle busy=0, key_out=0, no done, pass=fail=0.
  - rst at cycle 10 -> all outputs at reset values.
  - start pulses during a run -> ignored, run length unchanged.
- Back-to-back: start asserted on the done cycle -> new run begins, pass cleared, second run passes identically.
